uart_rx: RTL and testbench

- Serial receiver on the far end of the UART link: deserialises the line driven by the transmitter into bytes for the RX FIFO.
- 16x oversampled using the shared baud-tick enable.
- Checks optional parity and the stop bit.
- Emits a one-cycle strobe per received frame, consumed by the RX FIFO write port.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sync.sv | 27 ++
 rtl/uart_rx.sv | 176 +++++++++++++++++
 tb/tb_uart_rx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings, parity modes
// and default frame geometry used by the RX, TX and baud-generator blocks.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    // Mode 2'b11 is reserved and behaves as no parity.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_ODD) || (mode == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for a single asynchronous input; presets to 1 so an
// idle-high line does not look like activity coming out of reset.
module uart_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic a_reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (a_reset) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= d;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: qualifies the start bit at mid-bit, shifts in
// LSB-first data, checks optional parity and the stop bit, strobes rx_done.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int unsigned DATA_BITS   = UART_DATA_BITS,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 a_reset,
    input  logic                 b_tick,
    input  logic                 rx,
    input  logic [1:0]           parity,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic rx_s;

    uart_state_t          state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           par_mode_q, par_mode_d;
    logic                 par_err_q, par_err_d;
    logic                 armed_q, armed_d;

    logic [DATA_BITS-1:0] rx_data_d;
    logic                 rx_done_d;
    logic                 parity_err_d;
    logic                 frame_err_d;
    logic                 rx_busy_d;

    uart_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .a_reset (a_reset),
        .d       (rx),
        .q       (rx_s)
    );

    always_ff @(posedge clk) begin
        if (a_reset) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_mode_q <= PAR_NONE;
            par_err_q  <= 1'b0;
            armed_q    <= 1'b0;
            rx_data    <= '0;
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_mode_q <= par_mode_d;
            par_err_q  <= par_err_d;
            armed_q    <= armed_d;
            rx_data    <= rx_data_d;
            rx_done    <= rx_done_d;
            parity_err <= parity_err_d;
            frame_err  <= frame_err_d;
            rx_busy    <= rx_busy_d;
        end
    end

    // armed_q blocks a new start until the line has been seen high in idle,
    // so a held-low (break) line produces a single errored frame.
    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        par_mode_d   = par_mode_q;
        par_err_d    = par_err_q;
        armed_d      = armed_q;
        rx_data_d    = rx_data;
        rx_done_d    = 1'b0;
        parity_err_d = parity_err;
        frame_err_d  = frame_err;
        rx_busy_d    = rx_busy;

        if (b_tick) begin
            unique case (state_q)
                S_IDLE: begin
                    tick_d = '0;
                    if (rx_s) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d = S_START;
                    end
                end

                S_START: begin
                    if (tick_q == TICK_MID) begin
                        tick_d = '0;
                        if (!rx_s) begin
                            state_d    = S_DATA;
                            bit_d      = '0;
                            rx_busy_d  = 1'b1;
                            par_mode_d = parity;
                            par_err_d  = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                S_DATA: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d         = '0;
                        shift_d[bit_q] = rx_s;
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
                            state_d = parity_enabled(par_mode_q) ? S_PARITY : S_STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d    = '0;
                        par_err_d = (^shift_q) ^ rx_s ^ (par_mode_q == PAR_ODD);
                        state_d   = S_STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                S_STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d       = '0;
                        rx_data_d    = shift_q;
                        rx_done_d    = 1'b1;
                        parity_err_d = par_err_q;
                        frame_err_d  = ~rx_s;
                        rx_busy_d    = 1'b0;
                        armed_d      = rx_s;
                        state_d      = S_IDLE;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    tick_d  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven at 16 b_ticks per bit, one b_tick
// every 4 clk cycles; captured strobes are compared to hand-computed values.
module tb_uart_rx;

    localparam int BIT_CLKS = 64;

    logic       clk;
    logic       a_reset;
    logic       b_tick;
    logic       rx;
    logic [1:0] parity;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       parity_err;
    logic       frame_err;
    logic       rx_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_cnt = 0;

    logic [7:0] cap_data[$];
    logic       cap_pe[$];
    logic       cap_fe[$];
    logic       cap_busy[$];

    uart_rx #(
        .OVERSAMPLE  (16),
        .DATA_BITS   (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .a_reset    (a_reset),
        .b_tick     (b_tick),
        .rx         (rx),
        .parity     (parity),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        b_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            b_tick = 1'b1;
            @(negedge clk);
            b_tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rx_done) begin
            cap_data.push_back(rx_data);
            cap_pe.push_back(parity_err);
            cap_fe.push_back(frame_err);
            cap_busy.push_back(rx_busy);
        end
        if (rx_busy) busy_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic wait_bits(input int n);
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic use_par,
                              input logic par_bit, input logic stop_bit);
        rx = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_bits(1);
        end
        if (use_par) begin
            rx = par_bit;
            wait_bits(1);
        end
        rx = stop_bit;
        wait_bits(1);
    endtask

    task automatic get_frame(input int idx, output logic [7:0] d, output logic pe,
                             output logic fe, output logic bz);
        if (idx < cap_data.size()) begin
            d  = cap_data[idx];
            pe = cap_pe[idx];
            fe = cap_fe[idx];
            bz = cap_busy[idx];
        end else begin
            d  = 'x;
            pe = 1'bx;
            fe = 1'bx;
            bz = 1'bx;
        end
    endtask

    task automatic test_reset();
        a_reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        n_checks++; if (rx_done !== 1'b0) begin n_fail++; $display("FAIL reset_rx_done: got %b expected 0", rx_done); end
        n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_rx_busy: got %b expected 0", rx_busy); end
        a_reset = 1'b0;
        wait_bits(2);
    endtask

    task automatic test_no_parity(input logic [1:0] mode, input string tag);
        int n0;
        logic [7:0] d;
        logic pe, fe, bz;
        n0 = cap_data.size();
        parity = mode;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        get_frame(n0, d, pe, fe, bz);
        n_checks++; if (cap_data.size() !== n0 + 1) begin n_fail++; $display("FAIL %s_count: got %0d expected %0d", tag, cap_data.size() - n0, 1); end
        n_checks++; if (d !== 8'hA5) begin n_fail++; $display("FAIL %s_data: got %h expected a5", tag, d); end
        n_checks++; if (pe !== 1'b0) begin n_fail++; $display("FAIL %s_parity_err: got %b expected 0", tag, pe); end
        n_checks++; if (fe !== 1'b0) begin n_fail++; $display("FAIL %s_frame_err: got %b expected 0", tag, fe); end
        n_checks++; if (bz !== 1'b0) begin n_fail++; $display("FAIL %s_busy_at_done: got %b expected 0", tag, bz); end
    endtask

    task automatic test_parity();
        // {mode, data, parity bit, expected parity_err}
        logic [1:0] modes[4] = '{2'b10, 2'b10, 2'b01, 2'b01};
        logic [7:0] datas[4] = '{8'h07, 8'h07, 8'h00, 8'h00};
        logic       pbits[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       perrs[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int n0;
        logic [7:0] d;
        logic pe, fe, bz;
        for (int k = 0; k < 4; k++) begin
            n0 = cap_data.size();
            parity = modes[k];
            send_frame(datas[k], 1'b1, pbits[k], 1'b1);
            repeat (8) @(negedge clk);
            get_frame(n0, d, pe, fe, bz);
            n_checks++; if (cap_data.size() !== n0 + 1) begin n_fail++; $display("FAIL parity%0d_count: got %0d expected 1", k, cap_data.size() - n0); end
            n_checks++; if (d !== datas[k]) begin n_fail++; $display("FAIL parity%0d_data: got %h expected %h", k, d, datas[k]); end
            n_checks++; if (pe !== perrs[k]) begin n_fail++; $display("FAIL parity%0d_parity_err: got %b expected %b", k, pe, perrs[k]); end
            n_checks++; if (fe !== 1'b0) begin n_fail++; $display("FAIL parity%0d_frame_err: got %b expected 0", k, fe); end
        end
        parity = 2'b00;
    endtask

    task automatic test_break();
        int n0;
        logic [7:0] d;
        logic pe, fe, bz;
        n0 = cap_data.size();
        parity = 2'b00;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        get_frame(n0, d, pe, fe, bz);
        n_checks++; if (cap_data.size() !== n0 + 1) begin n_fail++; $display("FAIL break_count: got %0d expected 1", cap_data.size() - n0); end
        n_checks++; if (d !== 8'h3C) begin n_fail++; $display("FAIL break_data: got %h expected 3c", d); end
        n_checks++; if (fe !== 1'b1) begin n_fail++; $display("FAIL break_frame_err: got %b expected 1", fe); end
        wait_bits(33);
        n_checks++; if (cap_data.size() !== n0 + 1) begin n_fail++; $display("FAIL break_held_low: got %0d strobes expected 1", cap_data.size() - n0); end
        rx = 1'b1;
        wait_bits(2);
        n_checks++; if (cap_data.size() !== n0 + 1) begin n_fail++; $display("FAIL break_release: got %0d strobes expected 1", cap_data.size() - n0); end
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        get_frame(n0 + 1, d, pe, fe, bz);
        n_checks++; if (d !== 8'h55) begin n_fail++; $display("FAIL break_recover_data: got %h expected 55", d); end
        n_checks++; if (fe !== 1'b0) begin n_fail++; $display("FAIL break_recover_frame_err: got %b expected 0", fe); end
    endtask

    task automatic test_back_to_back();
        int n0, b0;
        logic [7:0] d;
        logic pe, fe, bz;
        n0 = cap_data.size();
        b0 = busy_cnt;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        wait_bits(2);
        n_checks++; if (busy_cnt !== b0) begin n_fail++; $display("FAIL glitch_busy: got %0d busy cycles expected 0", busy_cnt - b0); end
        n_checks++; if (cap_data.size() !== n0) begin n_fail++; $display("FAIL glitch_done: got %0d strobes expected 0", cap_data.size() - n0); end
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        n_checks++; if (cap_data.size() !== n0 + 2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", cap_data.size() - n0); end
        get_frame(n0, d, pe, fe, bz);
        n_checks++; if (d !== 8'h81) begin n_fail++; $display("FAIL b2b_first_data: got %h expected 81", d); end
        get_frame(n0 + 1, d, pe, fe, bz);
        n_checks++; if (d !== 8'h7E) begin n_fail++; $display("FAIL b2b_second_data: got %h expected 7e", d); end
        n_checks++; if (fe !== 1'b0) begin n_fail++; $display("FAIL b2b_second_frame_err: got %b expected 0", fe); end
    endtask

    task automatic test_reset_mid_frame();
        int n0;
        logic [7:0] abort_byte;
        logic [7:0] d;
        logic pe, fe, bz;
        abort_byte = 8'h33;
        n0 = cap_data.size();
        rx = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 4; i++) begin
            rx = abort_byte[i];
            wait_bits(1);
        end
        rx = abort_byte[4];
        repeat (BIT_CLKS / 2) @(negedge clk);
        n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL midframe_busy: got %b expected 1", rx_busy); end
        a_reset = 1'b1;
        @(negedge clk);
        a_reset = 1'b0;
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midreset_rx_data: got %h expected 00", rx_data); end
        n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_rx_busy: got %b expected 0", rx_busy); end
        n_checks++; if (rx_done !== 1'b0) begin n_fail++; $display("FAIL midreset_rx_done: got %b expected 0", rx_done); end
        rx = 1'b1;
        wait_bits(2);
        n_checks++; if (cap_data.size() !== n0) begin n_fail++; $display("FAIL midreset_no_strobe: got %0d strobes expected 0", cap_data.size() - n0); end
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        get_frame(n0, d, pe, fe, bz);
        n_checks++; if (cap_data.size() !== n0 + 1) begin n_fail++; $display("FAIL midreset_next_count: got %0d expected 1", cap_data.size() - n0); end
        n_checks++; if (d !== 8'h5A) begin n_fail++; $display("FAIL midreset_next_data: got %h expected 5a", d); end
        n_checks++; if (fe !== 1'b0) begin n_fail++; $display("FAIL midreset_next_frame_err: got %b expected 0", fe); end
    endtask

    initial begin
        a_reset = 1'b1;
        rx      = 1'b1;
        parity  = 2'b00;
        @(negedge clk);
        test_reset();
        test_no_parity(2'b00, "nopar");
        test_no_parity(2'b11, "par11");
        test_parity();
        test_break();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
